// File: rtl/riscv_cpu_pkg.sv
// Shared types for the instruction prefetch path: fetch FSM states, FIFO entry
// layout and the default buffer depth.
package riscv_cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID,
    DISCARD
  } prefetch_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int PREFETCH_FIFO_DEPTH_DEFAULT = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Small {addr, instr} FIFO for the prefetch buffer: push/pop/flush with
// occupancy count; head is read combinationally from the current read pointer.
module fetch_fifo
  import riscv_cpu_pkg::*;
#(
  parameter int DEPTH = PREFETCH_FIFO_DEPTH_DEFAULT,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  fetch_entry_t  wdata_i,
  output fetch_entry_t  rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW-1:0]   wr_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [DEPTH-1:0] wr_en;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (count_reg == CW'(DEPTH));
  assign empty_o = (count_reg == '0);
  assign count_o = count_reg;
  assign rdata_o = mem[rd_ptr_reg];

  // A push into a full FIFO is only honoured when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = do_push && !flush_i && (wr_ptr_reg == PW'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) mem[i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/prefetch_buffer.sv
// Instruction prefetch buffer: one-outstanding-request fetch FSM feeding a small
// FIFO toward IF. Define PREFETCH_BYPASS_EN to forward responses straight to fetch_* when empty.
module prefetch_buffer
  import riscv_cpu_pkg::*;
#(
  parameter int FIFO_DEPTH = PREFETCH_FIFO_DEPTH_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  output logic        busy_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  prefetch_state_e state_reg, state_next;
  logic [31:0]     fetch_addr_reg, fetch_addr_next;
  logic [31:0]     req_addr_reg, req_addr_next;
  logic            kill_reg, kill_next;
  logic            issue;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     count_after;
  fetch_entry_t    fifo_rdata, head;
  logic            rsp_accept;

  // A response is kept only for a live request and when no redirect arrives with it.
  assign rsp_accept = (state_reg == WAIT_RVALID) && instr_rvalid_i && !branch_i;

`ifdef PREFETCH_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit    = rsp_accept && fifo_empty;
  assign fetch_valid_o = !fifo_empty || bypass_hit;
  assign head          = fifo_empty ? {req_addr_reg, instr_rdata_i} : fifo_rdata;
  assign fifo_push     = rsp_accept && !(bypass_hit && fetch_ready_i);
  assign fifo_pop      = !fifo_empty && fetch_ready_i && !branch_i;
`else
  assign fetch_valid_o = !fifo_empty;
  assign head          = fifo_rdata;
  assign fifo_push     = rsp_accept;
  assign fifo_pop      = fetch_valid_o && fetch_ready_i && !branch_i;
`endif

  assign fetch_rdata_o = fetch_valid_o ? head.instr : '0;
  assign fetch_addr_o  = fetch_valid_o ? head.addr  : '0;
  assign busy_o        = (state_reg != IDLE);
  assign count_after   = {1'b0, fifo_count} + (CW + 1)'(fifo_push) - (CW + 1)'(fifo_pop);

  always_comb begin
    state_next      = state_reg;
    fetch_addr_next = fetch_addr_reg;
    req_addr_next   = req_addr_reg;
    kill_next       = kill_reg;
    issue           = 1'b0;
    instr_req_o     = 1'b0;
    instr_addr_o    = fetch_addr_reg;

    unique case (state_reg)
      // No new request on a redirect cycle: the address is about to change.
      IDLE: issue = req_i && !fifo_full && !branch_i;
      WAIT_GNT: begin
        instr_req_o  = 1'b1;
        instr_addr_o = req_addr_reg;
        if (instr_gnt_i) begin
          state_next = (kill_reg || branch_i) ? DISCARD : WAIT_RVALID;
          kill_next  = 1'b0;
          if (!kill_reg && !branch_i) fetch_addr_next = fetch_addr_reg + 32'd4;
        end else if (branch_i) begin
          kill_next = 1'b1;
        end
      end
      WAIT_RVALID: begin
        if (instr_rvalid_i) begin
          state_next = IDLE;
          issue      = rsp_accept && req_i && (count_after < DEPTH_W);
        end else if (branch_i) begin
          state_next = DISCARD;
        end
      end
      DISCARD: if (instr_rvalid_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (issue) begin
      instr_req_o   = 1'b1;
      instr_addr_o  = fetch_addr_reg;
      req_addr_next = fetch_addr_reg;
      if (instr_gnt_i) begin
        state_next      = WAIT_RVALID;
        fetch_addr_next = fetch_addr_reg + 32'd4;
      end else begin
        state_next = WAIT_GNT;
      end
    end

    if (branch_i) fetch_addr_next = {branch_addr_i[31:2], 2'b00};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      fetch_addr_reg <= '0;
      req_addr_reg   <= '0;
      kill_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fetch_addr_reg <= fetch_addr_next;
      req_addr_reg   <= req_addr_next;
      kill_reg       <= kill_next;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (branch_i),
    .wdata_i ({req_addr_reg, instr_rdata_i}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_prefetch_buffer.sv
// Bench for prefetch_buffer: directed scenarios then random traffic, every cycle
// compared against a transaction-level model built on a queue.
module tb_prefetch_buffer;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        fetch_valid_o;
  logic        fetch_ready_i = 1'b0;
  logic [31:0] fetch_rdata_o;
  logic [31:0] fetch_addr_o;
  logic        busy_o;

  always #5 clk = ~clk;

  prefetch_buffer #(.FIFO_DEPTH(D)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .fetch_valid_o  (fetch_valid_o),
    .fetch_ready_i  (fetch_ready_i),
    .fetch_rdata_o  (fetch_rdata_o),
    .fetch_addr_o   (fetch_addr_o),
    .busy_o         (busy_o)
  );

  int errors = 0;
  int checks = 0;

  // Model: queue of {addr, instr}, next fetch pc, and the lifecycle of the one request.
  logic [63:0] q[$];
  logic [31:0] pc, held;
  int          phase;   // 0 none, 1 issued awaiting gnt, 2 granted awaiting response
  bit          drop, kill;

  bit          exp_valid, exp_req, exp_busy, new_issue, pop;
  logic [31:0] exp_addr, exp_rdata, exp_iaddr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    pc = '0; held = '0; phase = 0; drop = 0; kill = 0;
  endfunction

  function automatic void predict();
    logic [63:0] h;
    int after;
    exp_valid = (q.size() > 0);
    h = exp_valid ? q[0] : 64'h0;
    exp_addr  = h[63:32];
    exp_rdata = h[31:0];
    exp_busy  = (phase != 0);
    pop       = exp_valid && fetch_ready_i && !branch_i;
    new_issue = 0;
    exp_req   = 0;
    exp_iaddr = pc;
    if (phase == 0) begin
      new_issue = req_i && (q.size() < D) && !branch_i;
    end else if (phase == 1) begin
      exp_req = 1; exp_iaddr = held;
    end else if (instr_rvalid_i && !drop && !branch_i) begin
      after = q.size() + 1 - (pop ? 1 : 0);
      new_issue = req_i && (after < D);
    end
    if (new_issue) begin exp_req = 1; exp_iaddr = pc; end
  endfunction

  function automatic void step();
    if (branch_i) q.delete();
    else if (pop) void'(q.pop_front());
    if (phase == 2 && instr_rvalid_i) begin
      if (!drop && !branch_i) q.push_back({held, instr_rdata_i});
      phase = 0; drop = 0;
    end else if (phase == 2 && branch_i) begin
      drop = 1;
    end else if (phase == 1) begin
      if (instr_gnt_i) begin
        drop = kill || branch_i;
        if (!(kill || branch_i)) pc = pc + 32'd4;
        phase = 2; kill = 0;
      end else if (branch_i) kill = 1;
    end
    if (new_issue) begin
      held = pc;
      if (instr_gnt_i) begin phase = 2; drop = 0; pc = pc + 32'd4; end
      else phase = 1;
    end
    if (branch_i) pc = branch_addr_i & 32'hFFFF_FFFC;
  endfunction

  task automatic drive(input logic br, input logic [31:0] ba, input logic rq, input logic g,
                       input logic rv, input logic [31:0] rd, input logic rdy);
    @(negedge clk);
    branch_i = br; branch_addr_i = ba; req_i = rq; instr_gnt_i = g;
    instr_rvalid_i = rv; instr_rdata_i = rd; fetch_ready_i = rdy;
    #1;
    predict();
    chk("fetch_valid", {31'b0, fetch_valid_o}, {31'b0, exp_valid});
    chk("fetch_addr", fetch_addr_o, exp_addr);
    chk("fetch_rdata", fetch_rdata_o, exp_rdata);
    chk("busy", {31'b0, busy_o}, {31'b0, exp_busy});
    chk("instr_req", {31'b0, instr_req_o}, {31'b0, exp_req});
    if (exp_req) chk("instr_addr", instr_addr_o, exp_iaddr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0; req_i = 0; branch_i = 0; instr_gnt_i = 0; instr_rvalid_i = 0; fetch_ready_i = 0;
    #1;
    model_reset();
    chk("rst_valid", {31'b0, fetch_valid_o}, 32'd0);
    chk("rst_req", {31'b0, instr_req_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_rdata", fetch_rdata_o, 32'd0);
    chk("rst_addr", fetch_addr_o, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [31:0] ba;
    do_reset();

    // Boot, first response, fill to depth with IF stalled
    drive(1, 32'h0000_1002, 1, 0, 0, 0, 0); step();
    drive(0, 0, 1, 1, 0, 0, 0);
    chk("boot_req", {31'b0, instr_req_o}, 32'd1);
    chk("boot_iaddr", instr_addr_o, 32'h1000);
    step();
    drive(0, 0, 1, 1, 1, 32'h0000_0013, 0); step();
    drive(0, 0, 1, 1, 1, 32'h0000_0017, 0);
    chk("first_valid", {31'b0, fetch_valid_o}, 32'd1);
    chk("first_addr", fetch_addr_o, 32'h1000);
    chk("first_rdata", fetch_rdata_o, 32'h13);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 0, 0, 0);
      chk("full_noreq", {31'b0, instr_req_o}, 32'd0);
      step();
    end
    drive(0, 0, 1, 1, 0, 0, 1); step();
    drive(0, 0, 1, 1, 0, 0, 0);
    chk("refill_iaddr", instr_addr_o, 32'h1008);
    chk("refill_head", fetch_addr_o, 32'h1004);
    step();

    // Redirect while awaiting 0x1008: stale response dropped
    drive(1, 32'h0000_2000, 1, 0, 0, 0, 0); step();
    drive(0, 0, 1, 0, 1, 32'hDEAD_BEEF, 0);
    chk("flush_valid", {31'b0, fetch_valid_o}, 32'd0);
    step();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 0, 0, 0, 0);
      chk("hold_iaddr", instr_addr_o, 32'h2000);
      chk("hold_req", {31'b0, instr_req_o}, 32'd1);
      step();
    end
    drive(0, 0, 1, 1, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 32'h0000_2013, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("redir_head", fetch_addr_o, 32'h2000);
    step();

    // Address wrap
    do_reset();
    drive(1, 32'hFFFF_FFFF, 1, 0, 0, 0, 0); step();
    drive(0, 0, 1, 1, 0, 0, 1);
    chk("wrap_first", instr_addr_o, 32'hFFFF_FFFC);
    step();
    drive(0, 0, 1, 1, 1, 32'h1111_0000, 1);
    chk("wrap_second", instr_addr_o, 32'h0000_0000);
    step();
    drive(0, 0, 0, 0, 1, 32'h2222_0000, 1); step();

    // Reset mid-transaction, stray rvalid afterwards
    do_reset();
    drive(1, 32'h0000_3000, 1, 0, 0, 0, 0); step();
    drive(0, 0, 1, 1, 0, 0, 0); step();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 1, 32'h5A5A_5A5A, 0);
      chk("stray_valid", {31'b0, fetch_valid_o}, 32'd0);
      chk("stray_busy", {31'b0, busy_o}, 32'd0);
      step();
    end

    // Random traffic against the model
    drive(1, 32'h0000_4000, 1, 0, 0, 0, 0); step();
    for (int n = 0; n < 800; n++) begin
      ba = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drive(($urandom_range(0, 15) == 0), ba, ($urandom_range(0, 7) != 0),
            1'($urandom_range(0, 1)), (phase == 2) && ($urandom_range(0, 1) == 1),
            $urandom, 1'($urandom_range(0, 1)));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prefetch_buffer.md
PREFETCH_BUFFER -- requirements
Module: prefetch_buffer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, number of buffered {addr, instr} entries (legal 2..8, power of 2).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_i  input  1  fetch enable; new memory requests are issued only while high.
REQ-005 SHALL have port branch_i  input  1  redirect pulse from the PC control path.
REQ-006 SHALL have port branch_addr_i  input  32  redirect target; bits [1:0] ignored, treated as 0.
REQ-007 SHALL have port instr_req_o  output  1  memory request.
REQ-008 SHALL have port instr_addr_o  output  32  memory request address, word-aligned.
REQ-009 SHALL have port instr_gnt_i  input  1  memory accepts the request this cycle.
REQ-010 SHALL have port instr_rvalid_i  input  1  instr_rdata_i is valid this cycle.
REQ-011 SHALL have port instr_rdata_i  input  32  fetched instruction word.
REQ-012 SHALL have port fetch_valid_o  output  1  FIFO head valid toward the IF stage.
REQ-013 SHALL have port fetch_ready_i  input  1  IF stage consumes head when fetch_valid_o is also high.
REQ-014 SHALL have port fetch_rdata_o  output  32  head instruction.
REQ-015 SHALL have port fetch_addr_o  output  32  head instruction address.
REQ-016 SHALL have port busy_o  output  1  high while any request is pending or awaiting response.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_GNT, WAIT_RVALID, DISCARD; at most one request outstanding.
REQ-018 IDLE -> WAIT_GNT, instr_req_o=1, instr_addr_o=fetch address, when req_i=1 and FIFO not full (counting no pending slot).
REQ-019 instr_req_o and instr_addr_o SHALL stay stable in WAIT_GNT until instr_gnt_i=1; branch_i never withdraws an issued request.
REQ-020 On gnt: fetch address += 4 (32-bit wrap, 0xFFFFFFFC -> 0x0); WAIT_GNT -> WAIT_RVALID.
REQ-021 In WAIT_RVALID with instr_rvalid_i=1: push {granted addr, instr_rdata_i}; in the same cycle a new request SHALL be issued if req_i=1 and a FIFO slot remains after the push, else -> IDLE.
REQ-022 branch_i: flush all FIFO entries same edge; fetch address <= branch_addr_i & ~3; fetch_valid_o=0 in next cycle.
REQ-023 branch_i in WAIT_GNT or WAIT_RVALID (without rvalid) -> after gnt, state DISCARD; response for the old request SHALL be dropped, then -> IDLE.
REQ-024 branch_i coincident with instr_rvalid_i: response dropped, no push; branch_i in DISCARD: address updated, stay DISCARD.
REQ-025 branch_i coincident with a fetch_valid_o/fetch_ready_i handshake: branch wins, flush, handshake has no further effect.
REQ-026 Simultaneous push and pop on a full FIFO SHALL be legal and keep count unchanged; push on full without pop SHALL never occur.
REQ-027 fetch_valid_o=1 iff FIFO count > 0 (see REQ-032 for bypass); head data stable while valid and not ready.
REQ-028 busy_o = (state != IDLE).

Reset
REQ-029 On rst_ni=0: state IDLE, FIFO empty, fetch address 32'h0000_0000, instr_req_o=0, fetch_valid_o=0, busy_o=0, fetch_rdata_o=0, fetch_addr_o=0.
REQ-030 Reset mid-transaction SHALL abandon the outstanding request; any rvalid arriving after reset release with no issued request SHALL be ignored.
REQ-031 Boot SHALL occur by a branch_i pulse carrying the boot address.

Configuration
REQ-032 Macro PREFETCH_BYPASS_EN defined: when FIFO empty and instr_rvalid_i accepted (not dropped), response SHALL drive fetch_* combinationally with fetch_valid_o=1 same cycle; if fetch_ready_i=1 it is not written to FIFO. Undefined: responses always enter FIFO, one-cycle minimum rvalid-to-valid latency.

Structure
REQ-033 riscv_cpu_pkg SHALL hold prefetch_state_e (4 states) and PREFETCH_FIFO_DEPTH_DEFAULT.
REQ-034 Storage SHALL be sub-module fetch_fifo (parameterised depth, push/pop/flush, count, full/empty).

Verification
REQ-035 branch_i with 0x0000_1000, gnt and rvalid each 1 cycle later, data 0x00000013 -> fetch_valid_o=1, fetch_addr_o=0x1000, fetch_rdata_o=0x00000013.
REQ-036 fetch_ready_i=0, continuous gnt/rvalid -> exactly FIFO_DEPTH entries (0x1000, 0x1004), then instr_req_o=0 until a pop.
REQ-037 branch_i to 0x2000 while in WAIT_RVALID for 0x1008 -> 0x1008 response dropped, next instr_addr_o=0x2000, no stale fetch_valid_o.
REQ-038 gnt withheld 5 cycles -> instr_req_o and instr_addr_o constant across all 5 cycles.
REQ-039 branch_i to 0xFFFF_FFFC, two fetches -> second instr_addr_o=0x0000_0000.
REQ-040 rst_ni low in WAIT_RVALID, stray rvalid after release -> FIFO stays empty, all outputs at reset values.
